// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
package regfile_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DATA_W = 32;
  localparam int NUM_REGS       = 32;
  localparam int ZERO_REG       = 0;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int idx;

  // Scan farthest-from-ptr first so the requester closest to ptr overwrites.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back port arbiter with registered RF write stage and busy scoreboard.
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      sb_set,
  input  logic [ADDR_W-1:0]         sb_set_addr,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

`ifdef WB_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= xfer && (sel_addr != ZERO_ADDR);
      if (xfer) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  // Set is applied after clear so a newly issued producer keeps its bit.
  always_comb begin
    busy_next = busy;
    if (rf_we) begin
      busy_next[rf_waddr] = 1'b0;
    end
    if (sb_set && (sb_set_addr != ZERO_ADDR)) begin
      busy_next[sb_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign rs1_busy = busy[rs1_addr] && (rs1_addr != ZERO_ADDR);
  assign rs2_busy = busy[rs2_addr] && (rs2_addr != ZERO_ADDR);

  // A busy register may only be re-issued on the cycle its write-back retires.
  a_no_double_set : assert property (@(posedge clk) disable iff (!rst_n)
    !(sb_set && (sb_set_addr != ZERO_ADDR) && busy[sb_set_addr] &&
      !(rf_we && (rf_waddr == sb_set_addr))));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed vectors, queued RF writes.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFail   = 0;

  regfile_wb_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    ({a1, a0}),
    .req_data    ({d1, d0}),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [4:0] addr0, input logic [31:0] data0,
                               input logic [4:0] addr1, input logic [31:0] data1,
                               input logic set, input logic [4:0] setAddr,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    req_valid   = valid;
    a0          = addr0;
    d0          = data0;
    a1          = addr1;
    d1          = data1;
    sb_set      = set;
    sb_set_addr = setAddr;
    rs1_addr    = rs1;
    rs2_addr    = rs2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Every RF write the DUT presents must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected none",
                 rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e.addr, e.data});
      end
    end
  end

  initial begin
    logic [1:0] expGrant;

    rst_n = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rf_we", {63'd0, rf_we}, 64'd0);
    checkOutput("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    checkOutput("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    checkOutput("reset_ready", {62'd0, req_ready}, 64'd0);
    checkOutput("reset_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    rst_n = 1'b1;

    // Contention: both requesters held valid for four transfers.
    nextCycle();
    applyStimulus(2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef WB_ARB_FIXED_PRIO_EN
      expGrant = 2'b01;
`else
      expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checkOutput("contention_grant", {62'd0, req_ready}, {62'd0, expGrant});
      if (expGrant == 2'b01) expQ.push_back('{addr: 5'd1, data: 32'h11});
      else                   expQ.push_back('{addr: 5'd2, data: 32'h22});
      nextCycle();
    end

    // Single write from requester 0.
    applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("single_ready", {62'd0, req_ready}, 64'd1);
    expQ.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    nextCycle();

    // x0 write is accepted but never written.
    applyStimulus(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("x0_ready", {62'd0, req_ready}, 64'd1);
    checkOutput("x0_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("x0_no_we", {63'd0, rf_we}, 64'd0);

    // Scoreboard lifecycle on r7.
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd7);
    @(negedge clk);
    checkOutput("sb7_before_edge", {63'd0, rs2_busy}, 64'd0);
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    @(negedge clk);
    checkOutput("sb7_set", {63'd0, rs2_busy}, 64'd1);
    nextCycle();
    applyStimulus(2'b10, 5'd0, 32'd0, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0, 5'd7);
    @(negedge clk);
    checkOutput("wb7_ready", {62'd0, req_ready}, 64'd2);
    expQ.push_back('{addr: 5'd7, data: 32'h77});
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    @(negedge clk);
    checkOutput("wb7_we", {63'd0, rf_we}, 64'd1);
    checkOutput("sb7_busy_during_we", {63'd0, rs2_busy}, 64'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("sb7_cleared", {63'd0, rs2_busy}, 64'd0);

    // Set and clear of r9 collide on the same edge.
    nextCycle();
    applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    @(negedge clk);
    checkOutput("wb9_ready", {62'd0, req_ready}, 64'd1);
    expQ.push_back('{addr: 5'd9, data: 32'h99});
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    @(negedge clk);
    checkOutput("sb9_before_edge", {63'd0, rs1_busy}, 64'd0);
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    @(negedge clk);
    checkOutput("sb9_set_wins", {63'd0, rs1_busy}, 64'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("sb9_holds", {63'd0, rs1_busy}, 64'd1);

    // Asynchronous reset while a write is in flight.
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd9);
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9);
    @(negedge clk);
    checkOutput("sb3_set", {63'd0, rs1_busy}, 64'd1);
    checkOutput("sb9_still_set", {63'd0, rs2_busy}, 64'd1);
    nextCycle();
    applyStimulus(2'b10, 5'd0, 32'd0, 5'd4, 32'h44, 1'b0, 5'd0, 5'd3, 5'd9);
    @(negedge clk);
    checkOutput("wb4_ready", {62'd0, req_ready}, 64'd2);
    expQ.push_back('{addr: 5'd4, data: 32'h44});
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9);
    checkOutput("pre_reset_we", {63'd0, rf_we}, 64'd1);
    #1;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_reset_we", {63'd0, rf_we}, 64'd0);
    checkOutput("async_reset_waddr", {59'd0, rf_waddr}, 64'd0);
    checkOutput("async_reset_wdata", {32'd0, rf_wdata}, 64'd0);
    checkOutput("async_reset_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    checkOutput("async_reset_rs2_busy", {63'd0, rs2_busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pointer restarts at requester 0 after reset.
    nextCycle();
    applyStimulus(2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("post_reset_grant", {62'd0, req_ready}, 64'd1);
    expQ.push_back('{addr: 5'd1, data: 32'h11});
    nextCycle();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    checkOutput("pending_writes", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
